sdp_ram_stream_reader: RTL and testbench

- Read-side master for an external sdp_distributed_ram_m instance.
- Accepts a burst command (start address, word count) and drives the RAM read port.
- Absorbs the RAM read latency (0 or 1 cycle, matching the RAM's OUT_REGISTERED setting) and presents the words as a valid/ready stream with full backpressure.
- Sits between a RAM filled by a writer and a downstream consumer: DMA, packetiser, etc.

---
 rtl/sdp_ram_stream_reader.sv | 122 ++++++++++++
 tb/tb_sdp_ram_stream_reader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_stream_reader.sv
// Burst read master for an sdp_distributed_ram_m: issues RAM reads for a command
// and re-times the returned words into a valid/ready stream with full backpressure.
module sdp_ram_stream_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [WORD_WIDTH-1:0] ram_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   issue_left;
    logic [ADDR_WIDTH:0]   out_left;
    logic [WORD_WIDTH-1:0] buf_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  inflight;
    logic                  capture;
    logic                  accept;
    logic                  issue;
    logic                  pop;
    logic                  last_pop;
    logic [2:0]            occupancy;

    assign accept    = cmd_valid && cmd_ready;
    assign m_valid   = (count != 2'd0);
    assign pop       = m_valid && m_ready;
    assign m_data    = buf_mem[rd_ptr];
    assign m_last    = m_valid && (out_left == (ADDR_WIDTH+1)'(1));
    assign last_pop  = pop && m_last;
    assign occupancy = {1'b0, count} + {2'b0, inflight};

    // A pop this cycle frees a slot before any read issued now can land.
    generate
        if (RD_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) inflight <= 1'b0;
                else     inflight <= issue;
            end
            assign capture = inflight;
        end else if (RD_LATENCY == 0) begin : g_lat0
            assign inflight = 1'b0;
            assign capture  = issue;
        end else begin : g_bad
            $error("sdp_ram_stream_reader: RD_LATENCY must be 0 or 1");
            assign inflight = 1'b0;
            assign capture  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = (state == IDLE);
        busy       = (state != IDLE);
        issue      = (state == ISSUE) && (occupancy < ({2'b0, pop} + 3'd2));
        unique case (state)
            IDLE:    if (accept && (cmd_len != '0)) state_next = ISSUE;
            ISSUE:   if (issue && (issue_left == (ADDR_WIDTH+1)'(1))) state_next = DRAIN;
            DRAIN:   if (last_pop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raddr      <= '0;
            issue_left <= '0;
            out_left   <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= '0;
            done       <= 1'b0;
        end else begin
            done <= last_pop || (accept && (cmd_len == '0));
            if (accept) begin
                raddr      <= cmd_addr;
                issue_left <= cmd_len;
                out_left   <= cmd_len;
            end
            if (issue) begin
                raddr      <= raddr + ADDR_WIDTH'(1);
                issue_left <= issue_left - (ADDR_WIDTH+1)'(1);
            end
            if (capture) begin
                buf_mem[wr_ptr] <= ram_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                out_left <= out_left - (ADDR_WIDTH+1)'(1);
            end
            unique case ({capture, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sdp_ram_stream_reader.sv
// Directed bench: two readers (registered and combinational RAM read) on a 16-word RAM
// holding addr i -> 0x100+i, checked every cycle against a queue model of the burst.
module tb_sdp_ram_stream_reader;

    localparam int AW = 4;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic          m_ready = 1'b0;

    logic          cmd_ready1, m_valid1, m_last1, busy1, done1;
    logic [AW-1:0] raddr1;
    logic [WW-1:0] ram_data1, m_data1;
    logic          cmd_ready0, m_valid0, m_last0, busy0, done0;
    logic [AW-1:0] raddr0;
    logic [WW-1:0] ram_data0, m_data0;

    logic          cmd_ready_s, m_valid_s, m_last_s, busy_s, done_s;
    logic [AW-1:0] raddr_s;
    logic [WW-1:0] m_data_s;

    always #5 clk = ~clk;

    sdp_ram_stream_reader #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready1),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .raddr(raddr1), .ram_data(ram_data1),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1),
        .busy(busy1), .done(done1)
    );

    sdp_ram_stream_reader #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .RD_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready0),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .raddr(raddr0), .ram_data(ram_data0),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_last(m_last0),
        .busy(busy0), .done(done0)
    );

    // RAM stand-ins: registered read for dut1, combinational read for dut0.
    always @(posedge clk) ram_data1 <= 32'h100 + 32'(raddr1);
    assign ram_data0 = 32'h100 + 32'(raddr0);

    always_comb begin
        cmd_ready_s = sel ? cmd_ready1 : cmd_ready0;
        m_valid_s   = sel ? m_valid1   : m_valid0;
        m_last_s    = sel ? m_last1    : m_last0;
        busy_s      = sel ? busy1      : busy0;
        done_s      = sel ? done1      : done0;
        raddr_s     = sel ? raddr1     : raddr0;
        m_data_s    = sel ? m_data1    : m_data0;
    end

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          armed = 1'b0;
    logic [32:0] exp_q[$];
    bit          exp_busy = 1'b0;
    bit          exp_done = 1'b0;
    logic [AW-1:0] start_addr = '0;
    int          popped = 0;
    bit          stall_prev = 1'b0;
    logic [WW-1:0] stall_data = '0;
    logic        stall_last = 1'b0;
    int          acc_cyc = 0;
    int          first_valid_cyc = -1;
    int          done_cyc = 0;
    logic [WW-1:0] hs_data[$];
    logic        hs_last[$];
    int          hs_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Runs once per cycle at the falling edge: compare outputs, then advance the model.
    task automatic model_step();
        logic [32:0]   front;
        logic [AW-1:0] lead;
        logic [AW-1:0] a;
        cyc++;
        if (armed) begin
            check("cmd_ready", 32'(cmd_ready_s), 32'(!exp_busy));
            check("busy", 32'(busy_s), 32'(exp_busy));
            check("done", 32'(done_s), 32'(exp_done));
            if (m_valid_s) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(m_valid_s), 32'd0);
                end else begin
                    front = exp_q[0];
                    check("m_data", m_data_s, front[31:0]);
                    check("m_last", 32'(m_last_s), 32'(front[32]));
                end
            end
            if (stall_prev) begin
                check("stall_valid", 32'(m_valid_s), 32'd1);
                check("stall_data", m_data_s, stall_data);
                check("stall_last", 32'(m_last_s), 32'(stall_last));
            end
            if (busy_s) begin
                lead = raddr_s - start_addr - AW'(popped);
                check("raddr_lead_le2", 32'(lead <= 2), 32'd1);
            end
        end
        exp_done = 1'b0;
        if (rst) begin
            exp_q.delete();
            exp_busy   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (done_s) done_cyc = cyc;
            if (m_valid_s && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid_s && m_ready && exp_q.size() > 0) begin
                front = exp_q.pop_front();
                hs_data.push_back(m_data_s);
                hs_last.push_back(m_last_s);
                hs_cyc.push_back(cyc);
                popped++;
                if (front[32]) begin
                    exp_busy = 1'b0;
                    exp_done = 1'b1;
                end
            end
            stall_prev = m_valid_s && !m_ready;
            stall_data = m_data_s;
            stall_last = m_last_s;
            if (cmd_valid && cmd_ready_s) begin
                acc_cyc = cyc;
                first_valid_cyc = -1;
                hs_data.delete();
                hs_last.delete();
                hs_cyc.delete();
                if (cmd_len == '0) begin
                    exp_done = 1'b1;
                end else begin
                    start_addr = cmd_addr;
                    popped     = 0;
                    exp_busy   = 1'b1;
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        a = cmd_addr + AW'(i);
                        exp_q.push_back({(i == int'(cmd_len) - 1), 32'h100 + 32'(a)});
                    end
                end
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are compared at the falling edge.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [AW:0] l);
        bit acc = 1'b0;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = cmd_ready_s;
            tick();
        end
        cmd_valid = 1'b0;
        check("cmd_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            seen = done_s;
            tick();
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        bit seen;
        int a_done;
        pat = 4'b1001;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst   = 1'b0;
        armed = 1'b1;
        check("rst_cmd_ready", 32'(cmd_ready1), 32'd1);
        check("rst_raddr", 32'(raddr1), 32'd0);
        check("rst_m_valid", 32'(m_valid1), 32'd0);
        check("rst_m_last", 32'(m_last1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);

        // Basic burst, registered RAM, consumer always ready.
        m_ready = 1'b1;
        send_cmd(4'd4, 5'd3);
        wait_done("t1_done_timeout");
        check("t1_count", hs_data.size(), 32'd3);
        check("t1_w0", hs_data[0], 32'h104);
        check("t1_w1", hs_data[1], 32'h105);
        check("t1_w2", hs_data[2], 32'h106);
        check("t1_last2", 32'(hs_last[2]), 32'd1);
        check("t1_last0", 32'(hs_last[0]), 32'd0);
        // Accept cycle + issue cycle + RAM register cycle, then valid.
        check("t1_first_valid", first_valid_cyc - acc_cyc, 32'd3);
        check("t1_back_to_back", hs_cyc[2] - hs_cyc[0], 32'd2);
        check("t1_done_after_last", done_cyc - hs_cyc[2], 32'd1);

        // Backpressure with m_ready 1,0,0,1 repeating; wraps from 15 to 0.
        send_cmd(4'd9, 5'd8);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            m_ready = pat[i % 4];
            seen = done_s;
            tick();
        end
        check("t2_done_timeout", 32'(seen), 32'd1);
        check("t2_count", hs_data.size(), 32'd8);
        check("t2_w0", hs_data[0], 32'h109);
        check("t2_w7", hs_data[7], 32'h100);
        check("t2_last7", 32'(hs_last[7]), 32'd1);

        // Full-RAM burst with wrap.
        m_ready = 1'b1;
        send_cmd(4'd14, 5'd16);
        wait_done("t3_done_timeout");
        check("t3_count", hs_data.size(), 32'd16);
        check("t3_w0", hs_data[0], 32'h10E);
        check("t3_w1", hs_data[1], 32'h10F);
        check("t3_w2", hs_data[2], 32'h100);
        check("t3_w15", hs_data[15], 32'h10D);
        check("t3_last15", 32'(hs_last[15]), 32'd1);
        check("t3_last14", 32'(hs_last[14]), 32'd0);
        check("t3_last_cycle", hs_cyc[15] - acc_cyc, 32'd18);

        // Zero-length command.
        send_cmd(4'd5, 5'd0);
        check("t4_busy", 32'(busy1), 32'd0);
        check("t4_cmd_ready", 32'(cmd_ready1), 32'd1);
        check("t4_done_pulse", 32'(done1), 32'd1);
        tick();
        check("t4_done_one_cycle", 32'(done1), 32'd0);
        check("t4_no_words", hs_data.size(), 32'd0);

        // Reset while two words sit in the buffer.
        m_ready = 1'b0;
        send_cmd(4'd3, 5'd2);
        for (int i = 0; i < 5; i++) tick();
        check("t5_pre_valid", 32'(m_valid1), 32'd1);
        check("t5_pre_busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_m_valid", 32'(m_valid1), 32'd0);
        check("t5_busy", 32'(busy1), 32'd0);
        check("t5_cmd_ready", 32'(cmd_ready1), 32'd1);
        check("t5_done", 32'(done1), 32'd0);
        tick();
        tick();
        m_ready = 1'b1;
        send_cmd(4'd7, 5'd2);
        wait_done("t5_done_timeout");
        check("t5_count", hs_data.size(), 32'd2);
        check("t5_w0", hs_data[0], 32'h107);
        check("t5_w1", hs_data[1], 32'h108);

        // Combinational RAM variant.
        sel = 1'b0;
        tick();
        send_cmd(4'd1, 5'd4);
        wait_done("t6_done_timeout");
        check("t6_count", hs_data.size(), 32'd4);
        check("t6_first_valid", first_valid_cyc - acc_cyc, 32'd2);
        check("t6_w0", hs_data[0], 32'h101);
        check("t6_w3", hs_data[3], 32'h104);
        check("t6_span", hs_cyc[3] - hs_cyc[0], 32'd3);

        // Back-to-back: second command held pending, accepted in the done cycle of the first.
        send_cmd(4'd5, 5'd3);
        send_cmd(4'd12, 5'd2);
        a_done = done_cyc;
        check("t7_accept_in_done_cycle", acc_cyc - a_done, 32'd0);
        wait_done("t7_done_timeout");
        check("t7_count", hs_data.size(), 32'd2);
        check("t7_w0", hs_data[0], 32'h10C);
        check("t7_w1", hs_data[1], 32'h10D);
        check("t7_first_valid", first_valid_cyc - acc_cyc, 32'd2);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
